// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Round-robin arbiter that lets N masters share one single-beat
//               64-bit peripheral bus. The optional access timeout is enabled
//               by defining the macro BUS_ARBITER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int N = 3
`ifdef BUS_ARBITER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    req_read,
  input  logic [N-1:0]    req_write,
  input  logic [N*64-1:0] req_address,
  input  logic [N*64-1:0] req_wdata,
  output logic [N-1:0]    grant,
  output logic [N-1:0]    done,
  output logic [N-1:0]    error,
  output logic [63:0]     rdata,
  output logic [63:0]     bus_address,
  output logic [63:0]     bus_wdata,
  output logic            bus_read,
  output logic            bus_write,
  input  logic [63:0]     bus_rdata,
  input  logic            bus_ready
);

  localparam int C_IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t             r_state;
  logic [C_IDX_W-1:0] r_last;
  logic [C_IDX_W-1:0] r_idx;

  logic [N-1:0]       w_elig;
  logic [N-1:0]       w_onehot;
  logic               w_found;
  logic [C_IDX_W-1:0] w_pick;
  logic [C_IDX_W-1:0] w_j;
  logic [63:0]        w_addr;
  logic [63:0]        w_wdata;

`ifdef BUS_ARBITER_TIMEOUT_EN
  logic [31:0] r_cnt;
  logic        w_expired;
  assign w_expired = (r_cnt + 32'd1) >= 32'(TIMEOUT_CYCLES);
`else
  assign error = '0;
`endif

  // Search starts just after the previous winner, so every master gets a turn.
  always_comb begin
    w_elig   = req & (req_read | req_write);
    w_found  = 1'b0;
    w_pick   = '0;
    w_j      = '0;
    w_onehot = '0;
    w_addr   = '0;
    w_wdata  = '0;
    for (int off = 1; off <= N; off++) begin
      w_j = C_IDX_W'((int'(r_last) + off) % N);
      if (!w_found && w_elig[w_j]) begin
        w_found = 1'b1;
        w_pick  = w_j;
      end
    end
    w_onehot[w_pick] = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (w_pick == C_IDX_W'(i)) begin
        w_addr  = req_address[64*i +: 64];
        w_wdata = req_wdata[64*i +: 64];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last      <= C_IDX_W'(N - 1);
      r_idx       <= '0;
      grant       <= '0;
      done        <= '0;
      rdata       <= '0;
      bus_address <= '0;
      bus_wdata   <= '0;
      bus_read    <= 1'b0;
      bus_write   <= 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
      error       <= '0;
      r_cnt       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_idx       <= w_pick;
            grant       <= w_onehot;
            bus_address <= w_addr;
            bus_wdata   <= w_wdata;
            // A read+write command is treated as a plain read.
            bus_read    <= req_read[w_pick];
            bus_write   <= req_write[w_pick] & ~req_read[w_pick];
            r_state     <= S_ACCESS;
`ifdef BUS_ARBITER_TIMEOUT_EN
            r_cnt       <= '0;
`endif
          end
        end
        S_ACCESS: begin
          if (bus_ready) begin
            rdata       <= bus_read ? bus_rdata : 64'd0;
            done        <= grant;
            bus_address <= '0;
            bus_wdata   <= '0;
            bus_read    <= 1'b0;
            bus_write   <= 1'b0;
            r_state     <= S_RESP;
          end
`ifdef BUS_ARBITER_TIMEOUT_EN
          else if (w_expired) begin
            rdata       <= '1;
            error       <= grant;
            bus_address <= '0;
            bus_wdata   <= '0;
            bus_read    <= 1'b0;
            bus_write   <= 1'b0;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
`endif
        end
        S_RESP: begin
          done    <= '0;
          grant   <= '0;
          r_last  <= r_idx;
          r_state <= S_IDLE;
`ifdef BUS_ARBITER_TIMEOUT_EN
          error   <= '0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Directed vector bench for bus_arbiter (N=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;
  localparam int N = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req, req_read, req_write;
  logic [N*64-1:0] req_address, req_wdata;
  logic [N-1:0]    grant, done, error;
  logic [63:0]     rdata, bus_address, bus_wdata, bus_rdata;
  logic            bus_read, bus_write, bus_ready;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  bus_arbiter #(
    .N(N)
`ifdef BUS_ARBITER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clock(clock), .reset(reset),
    .req(req), .req_read(req_read), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata),
    .grant(grant), .done(done), .error(error), .rdata(rdata),
    .bus_address(bus_address), .bus_wdata(bus_wdata),
    .bus_read(bus_read), .bus_write(bus_write),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  typedef struct {
    logic [2:0]  req, rd, wr;
    logic [63:0] abase, wbase;
    int          delay;
    logic [63:0] srd;
    int          exp_idx;
    logic        exp_rd, exp_wr;
    logic [63:0] exp_addr, exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [2:0] oh;
    oh = 3'b001 << v.exp_idx;
    req = v.req; req_read = v.rd; req_write = v.wr;
    for (int i = 0; i < N; i++) begin
      req_address[64*i +: 64] = v.abase + 64'(8 * i);
      req_wdata[64*i +: 64]   = v.wbase + 64'(i);
    end
    tick();
    chk("grant", grant, oh);
    chk("bus_read", bus_read, v.exp_rd);
    chk("bus_write", bus_write, v.exp_wr);
    chk("bus_address", bus_address, v.exp_addr);
    chk("bus_wdata", bus_wdata, v.wbase + 64'(v.exp_idx));
    chk("done_early", done, 0);
    bus_rdata = v.srd;
    for (int d = 0; d < v.delay; d++) begin
      tick();
      chk("wait_grant", grant, oh);
      chk("wait_done", done, 0);
    end
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    bus_rdata = '0;
    req[v.exp_idx] = 1'b0;
    chk("done", done, oh);
    chk("rdata", rdata, v.exp_rdata);
    chk("resp_grant", grant, oh);
    chk("resp_strobes", {bus_read, bus_write}, 0);
    chk("resp_address", bus_address, 0);
    tick();
    chk("done_single", done, 0);
    chk("idle_grant", grant, 0);
  endtask

  initial begin
    vecs[0] = '{3'b001, 3'b001, 3'b000, 64'h100,  64'h0,    0, 64'hDEAD, 0, 1'b1, 1'b0, 64'h100,  64'hDEAD};
    vecs[1] = '{3'b111, 3'b111, 3'b000, 64'h1000, 64'h10,   1, 64'h1111, 1, 1'b1, 1'b0, 64'h1008, 64'h1111};
    vecs[2] = '{3'b111, 3'b111, 3'b000, 64'h1000, 64'h10,   0, 64'h2222, 2, 1'b1, 1'b0, 64'h1010, 64'h2222};
    vecs[3] = '{3'b111, 3'b111, 3'b000, 64'h1000, 64'h10,   0, 64'h3333, 0, 1'b1, 1'b0, 64'h1000, 64'h3333};
    vecs[4] = '{3'b111, 3'b000, 3'b111, 64'h2000, 64'h20,   2, 64'h4444, 1, 1'b0, 1'b1, 64'h2008, 64'h0};
    vecs[5] = '{3'b111, 3'b101, 3'b010, 64'h3000, 64'h30,   0, 64'h5555, 2, 1'b1, 1'b0, 64'h3010, 64'h5555};
    vecs[6] = '{3'b010, 3'b010, 3'b010, 64'h1F8,  64'hCAFD, 0, 64'h6666, 1, 1'b1, 1'b0, 64'h200,  64'h6666};
    vecs[7] = '{3'b011, 3'b000, 3'b010, 64'h4000, 64'h40,   0, 64'h7777, 1, 1'b0, 1'b1, 64'h4008, 64'h0};
    vecs[8] = '{3'b101, 3'b101, 3'b000, 64'h5000, 64'h50,   1, 64'h8888, 2, 1'b1, 1'b0, 64'h5010, 64'h8888};

    reset = 1'b1; req = '0; req_read = '0; req_write = '0;
    req_address = '0; req_wdata = '0; bus_rdata = '0; bus_ready = 1'b0;
    tick(); tick();
    chk("rst_grant", grant, 0);
    chk("rst_done_error", {done, error}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bus", {bus_read, bus_write}, 0);
    chk("rst_address", bus_address | bus_wdata, 0);
    reset = 1'b0;
    tick();

    for (int k = 0; k < 9; k++) run_vec(vecs[k]);

    // Master 2 changes its address and drops req mid-access.
    req = 3'b100; req_read = 3'b100; req_write = '0;
    req_address[64*2 +: 64] = 64'hAAA0;
    tick();
    chk("mid_grant", grant, 3'b100);
    req_address[64*2 +: 64] = 64'hBBB0;
    req = '0;
    tick();
    chk("mid_address", bus_address, 64'hAAA0);
    chk("mid_read", bus_read, 1);
    bus_ready = 1'b1; bus_rdata = 64'h9999;
    tick();
    chk("mid_done", done, 3'b100);
    chk("mid_rdata", rdata, 64'h9999);
    bus_ready = 1'b1; bus_rdata = 64'h1234;
    tick();
    chk("mid_done_single", done, 0);
    // bus_ready while idle must be ignored and rdata held.
    tick();
    chk("idle_ready_done", done, 0);
    chk("idle_ready_grant", grant, 0);
    chk("rdata_hold", rdata, 64'h9999);
    bus_ready = 1'b0; bus_rdata = '0;

    // Reset during a stalled access.
    req = 3'b010; req_read = 3'b010;
    tick();
    chk("stall_grant", grant, 3'b010);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_grant", grant, 0);
    chk("rstmid_strobes", {bus_read, bus_write}, 0);
    chk("rstmid_done_error", {done, error}, 0);
    chk("rstmid_address", bus_address, 0);
    req = 3'b111; req_read = 3'b111;
    tick();
    chk("post_rst_grant", grant, 3'b001);
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    req = '0; req_read = '0;
    chk("post_rst_done", done, 3'b001);
    tick();

    // Slave never answers.
    req = 3'b001; req_read = 3'b001;
    req_address[63:0] = 64'h7000;
    tick();
    chk("to_grant", grant, 3'b001);
`ifdef BUS_ARBITER_TIMEOUT_EN
    for (int c = 0; c < 7; c++) begin
      tick();
      chk("to_wait_error", error, 0);
      chk("to_wait_grant", grant, 3'b001);
    end
    tick();
    req = '0; req_read = '0;
    chk("to_error", error, 3'b001);
    chk("to_done", done, 0);
    chk("to_rdata", rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("to_error_single", error, 0);
`else
    repeat (20) tick();
    chk("nto_grant", grant, 3'b001);
    chk("nto_read", bus_read, 1);
    chk("nto_done_error", {done, error}, 0);
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    req = '0; req_read = '0;
    chk("nto_done", done, 3'b001);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the single 64-bit peripheral bus (address, data, read, write) between multiple bus masters: the processor, GPU fetch engine and SD-card transfer engine. Each master posts one single-beat transaction at a time; the arbiter latches the winner's command, drives it onto the bus, waits for the addressed slave's ready, and returns read data with a one-cycle done pulse. It sits in the DE0 top level between the masters and the address-decoded peripherals.

## Interface
- N, 3, number of requesting masters (2..8)
- TIMEOUT_CYCLES, 1024, bus cycles before an unanswered access is aborted (timeout build only)

- clock  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-high
- req  in  N  per-master request; held until its done/error
- req_read  in  N  per-master read command
- req_write  in  N  per-master write command
- req_address  in  N*64  master i at [64i+63:64i]
- req_wdata  in  N*64  master i write data, same packing
- grant  out  N  one-hot owner of the bus; 0 when idle
- done  out  N  one-cycle completion pulse for master i
- error  out  N  one-cycle timeout pulse for master i
- rdata  out  64  read data, valid while done is high
- bus_address  out  64  shared bus address
- bus_wdata  out  64  shared bus write data
- bus_read  out  1  shared bus read strobe
- bus_write  out  1  shared bus write strobe
- bus_rdata  in  64  slave read data
- bus_ready  in  1  slave completion, sampled in ACCESS only

## Operation
- States: IDLE, ACCESS, RESP.
- Eligible master: req[i] & (req_read[i] | req_write[i]). Both read and write set: treated as read, write ignored.
- IDLE: if any eligible, winner = first eligible searching from last+1 upward, wrapping modulo N. Latch winner index, address, wdata, read/write; grant[winner]=1; -> ACCESS. None eligible: stay.
- ACCESS: bus_* driven solely from latched registers; later changes of req_* ignored. bus_ready=1 -> capture bus_rdata into rdata (writes: rdata=0), -> RESP.
- RESP: done[winner]=1 for this cycle only, grant still held; last=winner; -> IDLE.
- req dropped mid-ACCESS does not abort; transaction completes and done still pulses.
- Outside ACCESS: bus_read=bus_write=0, bus_address=bus_wdata=0.
- rdata holds its value until next RESP.

## Timing
- Reset values: state IDLE, grant=0, done=0, error=0, rdata=0, bus_address=0, bus_wdata=0, bus_read=0, bus_write=0, last=N-1 (master 0 wins first).
- Reset mid-ACCESS: bus strobes drop on the following edge; no done/error pulse.
- req sampled at edge k -> grant and bus strobes valid after edge k.
- bus_ready sampled at edge m (m>=k+1) -> done and rdata valid after edge m for one cycle.
- Minimum req-to-done: 2 cycles; back-to-back throughput one transaction per 3 cycles (IDLE, ACCESS, RESP).
- A master whose done pulses must not re-request until the cycle after done; re-request is then competing normally with rotated priority.
- bus_ready while not in ACCESS: ignored.

## Configuration
- BUS_ARBITER_TIMEOUT_EN defined: 32-bit counter cleared on ACCESS entry, incremented each ACCESS cycle; reaching TIMEOUT_CYCLES without bus_ready -> RESP with error[winner]=1 instead of done, rdata=64'hFFFF_FFFF_FFFF_FFFF. bus_ready on the same cycle as expiry wins (normal done).
- Not defined: no counter, ACCESS waits indefinitely, error tied to 0.

## Test plan
- Reset then single read by master 0, address 0x100, slave ready after 1 cycle with bus_rdata=0xDEAD -> grant=3'b001, bus_read=1, done[0] pulse, rdata=0xDEAD, req-to-done 2 cycles.
- All three masters request simultaneously and repeatedly -> grant order 0,1,2,0,1,2; exactly one done pulse per transaction.
- Master 1 write 0xCAFE to 0x200 with req_read=req_write=1 -> bus_read=1, bus_write=0 (read precedence).
- Master 2 changes req_address and drops req mid-ACCESS -> bus_address stays latched value, done[2] still pulses.
- Reset asserted during ACCESS with slave stalled -> next cycle all bus strobes 0, grant=0, no done/error; next request served by master 0.
- Timeout build, TIMEOUT_CYCLES=8, slave never ready -> error[winner] pulse after 8 ACCESS cycles, rdata=all ones, done stays 0; non-timeout build stays in ACCESS.
